// File: rtl/instr_exec_unit_pkg.sv
// Shared types and constants for the instruction execution unit.
// Opcodes 0..7 are legal; 8..15 are treated as illegal or as ZERO, set by a parameter.
package instr_exec_unit_pkg;

    typedef logic [3:0]  opcode_t;
    typedef logic [31:0] operand_t;
    typedef logic [63:0] operand_d_t;
    typedef logic [4:0]  address_t;

    localparam opcode_t OpZero  = 4'd0;
    localparam opcode_t OpPassA = 4'd1;
    localparam opcode_t OpPassB = 4'd2;
    localparam opcode_t OpAdd   = 4'd3;
    localparam opcode_t OpSub   = 4'd4;
    localparam opcode_t OpMult  = 4'd5;
    localparam opcode_t OpDiv   = 4'd6;
    localparam opcode_t OpMod   = 4'd7;

    localparam int unsigned ITERATIONS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } exec_state_t;

    typedef struct packed {
        operand_t   res;
        operand_d_t res_wide;
        address_t   addr;
        logic       ovf;
        logic       dz;
        logic       illegal;
    } exec_result_t;

    // Unsigned magnitude; INT_MIN maps to 0x80000000, which is exact as unsigned.
    function automatic operand_t magnitude(operand_t v);
        return v[31] ? operand_t'(-v) : v;
    endfunction

    function automatic operand_d_t sext(operand_t v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/instr_exec_unit_if.sv
// Request/response bundle between the instruction register and the execution unit.
interface instr_exec_unit_if;
    import instr_exec_unit_pkg::*;

    logic       in_valid;
    logic       in_ready;
    opcode_t    in_opc;
    operand_t   in_op_a;
    operand_t   in_op_b;
    address_t   in_addr;

    logic       out_valid;
    logic       out_ready;
    operand_t   out_res;
    operand_d_t out_res_wide;
    address_t   out_addr;
    logic       out_ovf;
    logic       out_dz;
    logic       out_illegal;

    modport master (
        output in_valid, in_opc, in_op_a, in_op_b, in_addr, out_ready,
        input  in_ready, out_valid, out_res, out_res_wide, out_addr, out_ovf, out_dz, out_illegal
    );

    modport slave (
        input  in_valid, in_opc, in_op_a, in_op_b, in_addr, out_ready,
        output in_ready, out_valid, out_res, out_res_wide, out_addr, out_ovf, out_dz, out_illegal
    );

endinterface

// File: rtl/instr_exec_unit_seqdiv.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per clock.
// Loads on start; busy stays high for exactly ITERATIONS edges after the load edge.
module instr_exec_seqdiv
    import instr_exec_unit_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  operand_t dividend,
    input  operand_t divisor,
    output logic     busy,
    output operand_t quotient,
    output operand_t remainder
);

    logic [5:0] cnt_q, cnt_d;
    operand_t   quo_q, quo_d;
    operand_t   rem_q, rem_d;
    operand_t   dvs_q, dvs_d;
    logic [32:0] shifted;
    logic [32:0] trial;

    assign busy      = (cnt_q != 6'd0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[31]};
        // Borrow out of bit 32 means the trial subtraction went negative: restore.
        trial   = shifted - {1'b0, dvs_q};
        if (start) begin
            cnt_d = 6'(ITERATIONS);
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (busy) begin
            cnt_d = cnt_q - 6'd1;
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: single-cycle simple ops, 32-iteration shift-add multiply and
// restoring divide/modulo on magnitudes with sign fix-up; result returned with its tag.
module instr_exec_unit
    import instr_exec_unit_pkg::*;
#(
    parameter bit ILLEGAL_IS_ERR = 1'b1
) (
    input logic              clk,
    input logic              reset,
    instr_exec_unit_if.slave bus
);

    localparam logic [5:0] LastIter = 6'(ITERATIONS - 1);

    exec_state_t  state_q, state_d;
    logic [5:0]   count_q, count_d;
    exec_result_t result_q, result_d;
    exec_result_t simple_res, iter_res, out_sel;
    opcode_t      opc_q, opc_d;
    logic         iter_q, iter_d;
    logic         neg_q, neg_d;
    logic         sign_a_q, sign_a_d;
    operand_d_t   mul_acc_q, mul_acc_d;
    operand_d_t   mul_mcand_q, mul_mcand_d;
    operand_t     mul_mplier_q, mul_mplier_d;
    operand_d_t   mul_prod;
    operand_t     mag_a, mag_b;
    operand_t     quo_s, rem_s;
    operand_t     div_quo, div_rem;
    logic         is_mul, is_div, div_start, div_busy;
    logic [32:0]  add_sum, sub_diff;

    assign mag_a    = magnitude(bus.in_op_a);
    assign mag_b    = magnitude(bus.in_op_b);
    assign is_mul   = (bus.in_opc == OpMult);
    assign is_div   = ((bus.in_opc == OpDiv) || (bus.in_opc == OpMod)) && (bus.in_op_b != '0);
    assign add_sum  = {bus.in_op_a[31], bus.in_op_a} + {bus.in_op_b[31], bus.in_op_b};
    assign sub_diff = {bus.in_op_a[31], bus.in_op_a} - {bus.in_op_b[31], bus.in_op_b};

    // Result for everything that completes on the accept edge.
    always_comb begin
        simple_res      = '0;
        simple_res.addr = bus.in_addr;
        case (bus.in_opc)
            OpZero, OpMult: simple_res.res = '0;
            OpPassA:        simple_res.res = bus.in_op_a;
            OpPassB:        simple_res.res = bus.in_op_b;
            OpAdd: begin
                simple_res.res = add_sum[31:0];
                simple_res.ovf = add_sum[32] ^ add_sum[31];
            end
            OpSub: begin
                simple_res.res = sub_diff[31:0];
                simple_res.ovf = sub_diff[32] ^ sub_diff[31];
            end
            OpDiv, OpMod:   simple_res.dz = (bus.in_op_b == '0);
            default:        simple_res.illegal = ILLEGAL_IS_ERR;
        endcase
        simple_res.res_wide = sext(simple_res.res);
    end

    instr_exec_seqdiv u_seqdiv (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        result_d     = result_q;
        opc_d        = opc_q;
        iter_d       = iter_q;
        neg_d        = neg_q;
        sign_a_d     = sign_a_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        div_start    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    result_d = simple_res;
                    opc_d    = bus.in_opc;
                    neg_d    = bus.in_op_a[31] ^ bus.in_op_b[31];
                    sign_a_d = bus.in_op_a[31];
                    iter_d   = is_mul || is_div;
                    count_d  = '0;
                    if (is_mul) begin
                        state_d      = StMul;
                        mul_acc_d    = '0;
                        mul_mcand_d  = {32'd0, mag_a};
                        mul_mplier_d = mag_b;
                    end else if (is_div) begin
                        state_d   = StDiv;
                        div_start = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StMul: begin
                if (mul_mplier_q[0]) begin
                    mul_acc_d = mul_acc_q + mul_mcand_q;
                end
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                count_d      = count_q + 6'd1;
                if (count_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (div_busy) begin
                    count_d = count_q + 6'd1;
                end
                if (count_q == LastIter) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Sign fix-up of the finished iterative result; registers are frozen in StDone.
    always_comb begin
        mul_prod = neg_q ? -mul_acc_q : mul_acc_q;
        quo_s    = neg_q ? -div_quo : div_quo;
        rem_s    = sign_a_q ? -div_rem : div_rem;
        iter_res = result_q;
        if (opc_q == OpMult) begin
            iter_res.res      = mul_prod[31:0];
            iter_res.res_wide = mul_prod;
            iter_res.ovf      = (mul_prod != sext(mul_prod[31:0]));
        end else if (opc_q == OpDiv) begin
            iter_res.res      = quo_s;
            iter_res.res_wide = sext(quo_s);
            // Only INT_MIN / -1 yields a positive quotient magnitude of 2^31.
            iter_res.ovf      = !neg_q && div_quo[31];
        end else begin
            iter_res.res      = rem_s;
            iter_res.res_wide = sext(rem_s);
        end
        out_sel = (state_q == StDone && iter_q) ? iter_res : result_q;
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StDone);
    assign bus.out_res      = out_sel.res;
    assign bus.out_res_wide = out_sel.res_wide;
    assign bus.out_addr     = out_sel.addr;
    assign bus.out_ovf      = out_sel.ovf;
    assign bus.out_dz       = out_sel.dz;
    assign bus.out_illegal  = out_sel.illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            result_q     <= '0;
            opc_q        <= OpZero;
            iter_q       <= 1'b0;
            neg_q        <= 1'b0;
            sign_a_q     <= 1'b0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            result_q     <= result_d;
            opc_q        <= opc_d;
            iter_q       <= iter_d;
            neg_q        <= neg_d;
            sign_a_q     <= sign_a_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized bench for instr_exec_unit: a transaction-level model predicts handshake
// timing and results; one negedge process compares every cycle.
module tb_instr_exec_unit;
    import instr_exec_unit_pkg::*;

    localparam bit     IllegalIsErr = 1'b1;
    localparam longint IntMax       = 2147483647;
    localparam longint IntMin       = -IntMax - 1;

    typedef struct {
        logic [31:0] res;
        logic [63:0] wide;
        logic        ovf;
        logic        dz;
        logic        ill;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_exec_unit_if bus ();

    instr_exec_unit #(.ILLEGAL_IS_ERR(IllegalIsErr)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec      = 0;
    int n_err      = 0;
    int cyc        = 0;
    int acc_cnt    = 0;
    int stall_left = 0;
    int rdy_mode   = 0;

    bit          pend     = 1'b0;
    bit          zero_chk = 1'b0;
    int          due      = 0;
    exp_t        exp_q;
    logic [4:0]  exp_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference semantics from plain signed 64-bit arithmetic.
    function automatic exp_t model(logic [3:0] opc, logic [31:0] a, logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        bit     mult;
        sa   = longint'(signed'(a));
        sb   = longint'(signed'(b));
        r    = 0;
        mult = 1'b0;
        e    = '{res: '0, wide: '0, ovf: 1'b0, dz: 1'b0, ill: 1'b0};
        case (opc)
            4'd0: r = 0;
            4'd1: r = sa;
            4'd2: r = sb;
            4'd3: begin r = sa + sb; e.ovf = (r > IntMax) || (r < IntMin); end
            4'd4: begin r = sa - sb; e.ovf = (r > IntMax) || (r < IntMin); end
            4'd5: begin r = sa * sb; mult = 1'b1; e.ovf = (r > IntMax) || (r < IntMin); end
            4'd6: if (sb == 0) e.dz = 1'b1; else begin r = sa / sb; e.ovf = (r > IntMax); end
            4'd7: if (sb == 0) e.dz = 1'b1; else r = sa % sb;
            default: e.ill = IllegalIsErr;
        endcase
        e.res  = r[31:0];
        e.wide = mult ? 64'(r) : {{32{r[31]}}, r[31:0]};
        return e;
    endfunction

    function automatic bit is_iter(logic [3:0] opc, logic [31:0] b);
        return (opc == 4'd5) || (((opc == 4'd6) || (opc == 4'd7)) && (b != 32'd0));
    endfunction

    // Compare current outputs, then advance the model for the coming edge.
    always @(negedge clk) begin
        bit exp_valid;
        exp_valid = pend && (cyc >= due);
        if (zero_chk) begin
            check("reset_in_ready", 64'(bus.in_ready), 64'(1));
            check("reset_out_valid", 64'(bus.out_valid), 64'(0));
            check("reset_res", 64'(bus.out_res), 64'(0));
            check("reset_res_wide", bus.out_res_wide, 64'(0));
            check("reset_flags", 64'({bus.out_addr, bus.out_ovf, bus.out_dz, bus.out_illegal}),
                  64'(0));
            zero_chk = 1'b0;
        end else begin
            check("in_ready", 64'(bus.in_ready), 64'(!pend));
            check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("res", 64'(bus.out_res), 64'(exp_q.res));
                check("res_wide", bus.out_res_wide, exp_q.wide);
                check("addr", 64'(bus.out_addr), 64'(exp_addr));
                check("ovf", 64'(bus.out_ovf), 64'(exp_q.ovf));
                check("dz", 64'(bus.out_dz), 64'(exp_q.dz));
                check("illegal", 64'(bus.out_illegal), 64'(exp_q.ill));
            end
        end
        if (reset) begin
            pend     = 1'b0;
            zero_chk = 1'b1;
        end else if (exp_valid && bus.out_ready) begin
            pend = 1'b0;
        end else if (!pend && bus.in_valid) begin
            exp_q    = model(bus.in_opc, bus.in_op_a, bus.in_op_b);
            exp_addr = bus.in_addr;
            due      = cyc + 1 + (is_iter(bus.in_opc, bus.in_op_b) ? int'(ITERATIONS) : 0);
            pend     = 1'b1;
            acc_cnt++;
        end
    end

    task automatic issue(logic [3:0] opc, logic [31:0] a, logic [31:0] b, logic [4:0] addr);
        int start;
        bit got;
        start        = acc_cnt;
        got          = 1'b0;
        bus.in_opc   = opc;
        bus.in_op_a  = a;
        bus.in_op_b  = b;
        bus.in_addr  = addr;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) got = 1'b1;
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept, expected one for opc %0d", opc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && pend; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(pend), 64'(0));
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [3:0] opc;
        int r;

        bus.in_valid  = 1'b0;
        bus.in_opc    = '0;
        bus.in_op_a   = '0;
        bus.in_op_b   = '0;
        bus.in_addr   = '0;
        bus.out_ready = 1'b1;

        // Hand-computed anchors for the model.
        e = model(4'd3, 32'h7FFF_FFFF, 32'd1);
        check("model_add_res", 64'(e.res), 64'h8000_0000);
        check("model_add_ovf", 64'(e.ovf), 64'(1));
        e = model(4'd5, -32'sd7, 32'd6);
        check("model_mul_wide", e.wide, 64'hFFFF_FFFF_FFFF_FFD6);
        e = model(4'd5, 32'h0001_0000, 32'h0001_0000);
        check("model_mul_big", e.wide, 64'h0000_0001_0000_0000);
        check("model_mul_ovf", 64'({e.ovf, e.res}), 64'h1_0000_0000);
        e = model(4'd6, -32'sd7, 32'd2);
        check("model_div", 64'(e.res), 64'hFFFF_FFFD);
        e = model(4'd7, -32'sd7, 32'd2);
        check("model_mod", 64'(e.res), 64'hFFFF_FFFF);
        e = model(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check("model_div_min", 64'({e.ovf, e.res}), 64'h1_8000_0000);
        e = model(4'd6, 32'd5, 32'd0);
        check("model_dz", 64'({e.dz, e.res}), 64'h1_0000_0000);
        e = model(4'hC, 32'd5, 32'd3);
        check("model_illegal", 64'({e.ill, e.res}), 64'h1_0000_0000);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rdy_mode = 0;
        issue(4'd3, 32'h7FFF_FFFF, 32'd1, 5'd3);
        issue(4'd5, -32'sd7, 32'd6, 5'd4);
        issue(4'd5, 32'h0001_0000, 32'h0001_0000, 5'd5);
        issue(4'd6, -32'sd7, 32'd2, 5'd6);
        issue(4'd7, -32'sd7, 32'd2, 5'd7);
        issue(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        issue(4'd6, 32'd5, 32'd0, 5'd10);
        issue(4'hC, 32'd1, 32'd2, 5'd11);

        // Backpressure: result held while a new instruction waits.
        issue(4'd1, 32'hDEAD_BEEF, 32'd0, 5'd12);
        bus.out_ready = 1'b0;
        stall_left    = 10;
        issue(4'd4, 32'h8000_0000, 32'd1, 5'd13);

        // Reset in the middle of a division.
        issue(4'd6, 32'd1000, 32'd7, 5'd14);
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(4'd2, 32'd0, 32'd9, 5'd15);

        rdy_mode = 1;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            r   = int'($urandom_range(0, 9));
            opc = (r < 8) ? 4'(r) : 4'($urandom_range(8, 15));
            issue(opc, rand_op(), rand_op(), 5'($urandom_range(0, 31)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
